// File: rtl/sram_controller_pkg.sv
// Shared constants and types for the SRAM data-memory controller.
//   DEF_* localparams  default geometry and timing of the external SRAM
//   state_t            controller FSM state encoding
//   cnt_width()        phase counter width for a given wait-cycle count
package sram_controller_pkg;

  localparam int DEF_WORD_WIDTH      = 32;
  localparam int DEF_SRAM_DATA_WIDTH = 16;
  localparam int DEF_SRAM_ADDR_WIDTH = 18;
  localparam int DEF_WAIT_CYCLES     = 1;
  localparam int DEF_DATA_MEM_BASE   = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counter must hold 0..wait_cycles; keep at least one bit when wait_cycles=0.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Clearable up-counter timing one half-word SRAM phase.
//   clk   system clock
//   rst   synchronous active-high reset
//   clr   restart the count at 0 on the next edge
//   last  high while the count equals WAIT_CYCLES (final cycle of a phase)
module sram_phase_counter
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last
);

  localparam int CW = cnt_width(WAIT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

  assign last = (cnt == CW'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Mem-stage data-memory responder backed by a 16-bit external SRAM.
// Each 32-bit access is split into a low and a high half-word phase.
//   clk, rst             system clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN   load / store request (store wins if both)
//   ALU_res, Val_Rm      byte address, store data
//   ready                1 = idle with no request, or access finished; 0 = freeze pipeline
//   read_data            last load result
//   SRAM_ADDR            half-word address
//   SRAM_DQ              bidirectional data, driven only in write phases
//   SRAM_WE_N            active-low write enable
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR       = DEF_DATA_MEM_BASE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MEM_R_EN,
  input  logic                       MEM_W_EN,
  input  logic [WORD_WIDTH-1:0]      ALU_res,
  input  logic [WORD_WIDTH-1:0]      Val_Rm,
  output logic                       ready,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_WIDTH-1:0] SRAM_DQ,
  output logic                       SRAM_WE_N
);

  localparam int HW = SRAM_DATA_WIDTH;
  localparam int AW = SRAM_ADDR_WIDTH;

  state_t          state;
  logic            last;
  logic            in_phase;
  logic            clr;
  logic [WORD_WIDTH-1:0] offset;
  logic [AW-2:0]   word_d;   // word index of the incoming request
  logic [AW-2:0]   word_q;   // word index latched at IDLE exit
  logic [HW-1:0]   wdata_hi; // upper store half, kept for the second phase
  logic [HW-1:0]   dq_out;
  logic            dq_oe;
  logic            unused_offset;

  // Byte address -> word index; truncation makes out-of-range addresses wrap.
  assign offset        = ALU_res - WORD_WIDTH'(BASE_ADDR);
  assign word_d        = offset[AW:2];
  assign unused_offset = ^{offset[1:0], offset[WORD_WIDTH-1:AW+1]};

  assign in_phase = (state == RD_LO) || (state == RD_HI) ||
                    (state == WR_LO) || (state == WR_HI);
  // Hold the counter at 0 outside phases and restart it at every phase boundary.
  assign clr = !in_phase || last;

  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .last (last)
  );

  assign ready   = (state == DONE) || ((state == IDLE) && !MEM_R_EN && !MEM_W_EN);
  assign SRAM_DQ = dq_oe ? dq_out : {HW{1'bz}};

  // Bus outputs are registered alongside the state so WE_N/DQ enable change
  // only on clock edges and cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      wdata_hi  <= '0;
      word_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state     <= WR_LO;
            word_q    <= word_d;
            wdata_hi  <= Val_Rm[WORD_WIDTH-1:HW];
            SRAM_ADDR <= {word_d, 1'b0};
            SRAM_WE_N <= 1'b0;
            dq_oe     <= 1'b1;
            dq_out    <= Val_Rm[HW-1:0];
          end else if (MEM_R_EN) begin
            state     <= RD_LO;
            word_q    <= word_d;
            SRAM_ADDR <= {word_d, 1'b0};
          end
        end
        RD_LO: if (last) begin
          read_data[HW-1:0] <= SRAM_DQ;
          state             <= RD_HI;
          SRAM_ADDR         <= {word_q, 1'b1};
        end
        RD_HI: if (last) begin
          read_data[WORD_WIDTH-1:HW] <= SRAM_DQ;
          state                      <= DONE;
        end
        WR_LO: if (last) begin
          state     <= WR_HI;
          SRAM_ADDR <= {word_q, 1'b1};
          dq_out    <= wdata_hi;
        end
        WR_HI: if (last) begin
          state     <= DONE;
          SRAM_WE_N <= 1'b1;
          dq_oe     <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: transaction-level model of the controller plus a
// 256K x 16 asynchronous SRAM that drives the bus whenever WE_N is high.
module tb_sram_controller;

  localparam int P = 2; // phase length = WAIT_CYCLES+1

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_res, Val_Rm;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .ALU_res   (ALU_res),
    .Val_Rm    (Val_Rm),
    .ready     (ready),
    .read_data (read_data),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // External SRAM: output enable tied on, so it drives whenever not writing.
  logic [15:0] sram [0:262143];
  assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR] <= SRAM_DQ;

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 40503) ^ 32'h5A5A);
  endfunction

  // Reference memory contents (addresses not written hold the fill pattern).
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input int k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return pat(k);
  endfunction

  function automatic logic [17:0] half_lo(input logic [31:0] a);
    logic [31:0] wd;
    wd = (a - 32'd1024) >> 2;
    return {wd[16:0], 1'b0};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle expectations set by the stimulus, checked mid-cycle.
  logic        e_chk = 1'b0, e_ready = 1'b1, e_we_n = 1'b1;
  logic        e_addr_chk = 1'b0, e_dq_chk = 1'b0, e_rel = 1'b0, e_rd_chk = 1'b0;
  logic [17:0] e_addr = '0;
  logic [15:0] e_dq = '0;
  logic [31:0] e_rd = '0;
  int          we_low_cnt = 0;

  always @(negedge clk) begin
    if (SRAM_WE_N === 1'b0) we_low_cnt++;
    if (e_chk) begin
      chk("ready", 32'(ready), 32'(e_ready));
      chk("sram_we_n", 32'(SRAM_WE_N), 32'(e_we_n));
      if (e_addr_chk) chk("sram_addr", 32'(SRAM_ADDR), 32'(e_addr));
      if (e_dq_chk)   chk("dq_write", 32'(SRAM_DQ), 32'(e_dq));
      if (e_rel)      chk("dq_released", 32'(SRAM_DQ), 32'(sram[SRAM_ADDR]));
      if (e_rd_chk)   chk("read_data", read_data, e_rd);
    end
  end

  task automatic set_idle_exp(input logic rdy);
    e_ready = rdy; e_we_n = 1'b1; e_addr_chk = 1'b0;
    e_dq_chk = 1'b0; e_rel = 1'b1; e_rd_chk = 1'b1;
  endtask

  task automatic rand_inputs();
    MEM_R_EN = 1'($urandom); MEM_W_EN = 1'($urandom);
    ALU_res = $urandom; Val_Rm = $urandom;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One request (or one idle cycle when r=w=0) from IDLE through DONE.
  // stop_k>0 pulses reset in phase cycle stop_k instead of completing.
  task automatic txn(input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit rand_mid, input int stop_k);
    logic [17:0] b;
    bit is_w;
    b = half_lo(a);
    is_w = w;
    MEM_R_EN = r; MEM_W_EN = w; ALU_res = a; Val_Rm = d;
    set_idle_exp(!(r || w));
    step();
    if (!(r || w)) return;
    for (int k = 1; k <= 2 * P; k++) begin
      if (rand_mid) rand_inputs();
      e_ready = 1'b0; e_we_n = !is_w; e_addr_chk = 1'b1;
      e_addr = b + 18'((k - 1) / P);
      e_dq_chk = is_w; e_dq = (k <= P) ? d[15:0] : d[31:16];
      e_rel = !is_w; e_rd_chk = 1'b0;
      if (k == stop_k) begin
        rst = 1'b1;
        step();
        rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        e_rd = '0;
        set_idle_exp(1'b1);
        e_addr_chk = 1'b1; e_addr = '0;
        step();
        return;
      end
      step();
    end
    if (is_w) begin
      ref_mem[int'(b)]     = d[15:0];
      ref_mem[int'(b) + 1] = d[31:16];
    end else begin
      e_rd = {ref_rd(int'(b) + 1), ref_rd(int'(b))};
    end
    if (rand_mid) rand_inputs();
    set_idle_exp(1'b1);
    step();
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = pat(i);
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_res = '0; Val_Rm = '0;

    // Reset state, checked while reset is still held.
    step();
    set_idle_exp(1'b1);
    e_addr_chk = 1'b1; e_addr = '0; e_rd = '0;
    e_chk = 1'b1;
    step();
    rst = 1'b0;

    // Idle cycles.
    for (int i = 0; i < 10; i++) txn(1'b0, 1'b0, $urandom, $urandom, 1'b0, 0);

    // Store 0xDEADBEEF to 1028.
    we_low_cnt = 0;
    txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 0);
    chk("t3_sram2", 32'(sram[2]), 32'h0000BEEF);
    chk("t3_sram3", 32'(sram[3]), 32'h0000DEAD);
    chk("t3_we_low_cycles", 32'(we_low_cnt), 32'd4);

    // Load it back.
    txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 0);
    chk("t4_read_data", read_data, 32'hDEADBEEF);
    chk("t4_sram2", 32'(sram[2]), 32'h0000BEEF);

    // Both enables: store wins.
    txn(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, 0);
    chk("t5_sram4", 32'(sram[4]), 32'h00005678);
    chk("t5_sram5", 32'(sram[5]), 32'h00001234);

    // Reset during RD_HI, then a normal store and load.
    txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, P + 1);
    txn(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0, 0);
    chk("t6_sram8", 32'(sram[8]), 32'h0000F00D);
    chk("t6_sram9", 32'(sram[9]), 32'h0000CAFE);
    txn(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 0);
    chk("t6_read_data", read_data, 32'hCAFEF00D);

    // Randomized traffic with inputs scrambled while the pipeline is frozen.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      txn(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8,
          pick_addr(), $urandom, 1'b1, 0);
    end
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    step();
    e_chk = 1'b0;

    foreach (ref_mem[k]) chk("sram_final", 32'(sram[k]), 32'(ref_mem[k]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
